modexp_word_port: RTL and testbench

- Core-side responder for the word-serial operand/result protocol that feeds the 4096-bit modular exponentiation engine.
- Receives five operand streams (message, exponent, modulus, R mod N, R² mod N) one DATA_WIDTH word per beat, least-significant word first, into internal word banks.
- Exposes those banks to the exponentiation datapath through a random-access read port.
- Collects result words written by the datapath and streams them back out word-serially on request.

---
 rtl/modexp_word_port.sv | 189 ++++++++++++++++++
 tb/tb_modexp_word_port.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_word_port.sv
// Word-serial operand loader, random-access bank read port and result streamer for the modexp engine.
// Latency: operand/result writes land on the next edge; rd_data and res_out are registered (1 cycle).
// Backpressure: none; sources pace beats with in_valid, and the result stream runs one word per cycle once started.
module modexp_word_port #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 64,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] m_word,
    input  logic [DATA_WIDTH-1:0] e_word,
    input  logic [DATA_WIDTH-1:0] n_word,
    input  logic [DATA_WIDTH-1:0] r_word,
    input  logic [DATA_WIDTH-1:0] t_word,
    input  logic [63:0]           nprime0_in,
    output logic                  loaded,
    output logic                  load_err,
    output logic [63:0]           nprime0,
    input  logic [2:0]            rd_sel,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  res_we,
    input  logic [AW-1:0]         res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  out_start,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

    state_t state_q;
    state_t state_d;

    logic [AW-1:0] beat_cnt;
    logic [AW-1:0] stream_cnt;
    logic [AW-1:0] stream_nxt;
    logic          beat_we;
    logic          stream_go;
    logic          stream_end;

    logic [DATA_WIDTH-1:0] m_bank   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] e_bank   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] n_bank   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] r_bank   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] t_bank   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] res_bank [NUM_WORDS];

    assign busy       = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign stream_nxt = stream_cnt + AW'(1);
    assign stream_end = (state_q == S_STREAM) && (stream_cnt == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_start overrides everything, including a same-cycle beat.
    always_comb begin
        state_d   = state_q;
        beat_we   = 1'b0;
        stream_go = 1'b0;
        if (load_start) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (in_valid) begin
                        beat_we = 1'b1;
                        if (beat_cnt == LAST_IDX) begin
                            state_d = S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (out_start) begin
                        stream_go = 1'b1;
                        state_d   = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (stream_end) begin
                        state_d = S_READY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and output registers: load bookkeeping, error flag and result streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded     <= 1'b0;
            load_err   <= 1'b0;
            nprime0    <= '0;
            beat_cnt   <= '0;
            stream_cnt <= '0;
            res_valid  <= 1'b0;
            res_last   <= 1'b0;
            res_out    <= '0;
        end else if (load_start) begin
            loaded    <= 1'b0;
            load_err  <= 1'b0;
            nprime0   <= nprime0_in;
            beat_cnt  <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
        end else begin
            if (beat_we) begin
                beat_cnt <= beat_cnt + AW'(1);
                if (beat_cnt == LAST_IDX) begin
                    loaded <= 1'b1;
                end
            end
            if (in_valid && (state_q != S_LOAD)) begin
                load_err <= 1'b1;
            end
            // The word for the current counter is registered, so the first word shows the cycle after out_start.
            if (stream_go) begin
                stream_cnt <= '0;
                res_out    <= res_bank[0];
                res_valid  <= 1'b1;
                res_last   <= (LAST_IDX == '0);
            end else if (state_q == S_STREAM) begin
                if (stream_end) begin
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                end else begin
                    stream_cnt <= stream_nxt;
                    res_out    <= res_bank[stream_nxt];
                    res_last   <= (stream_nxt == LAST_IDX);
                end
            end
        end
    end

    // Registered bank read port, valid in every state; unused selects read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            case (rd_sel)
                3'd0:    rd_data <= m_bank[rd_addr];
                3'd1:    rd_data <= e_bank[rd_addr];
                3'd2:    rd_data <= n_bank[rd_addr];
                3'd3:    rd_data <= r_bank[rd_addr];
                3'd4:    rd_data <= t_bank[rd_addr];
                default: rd_data <= '0;
            endcase
        end
    end

    // Operand banks: all five words of a beat land at the beat counter; contents survive reset.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            m_bank[beat_cnt] <= m_word;
            e_bank[beat_cnt] <= e_word;
            n_bank[beat_cnt] <= n_word;
            r_bank[beat_cnt] <= r_word;
            t_bank[beat_cnt] <= t_word;
        end
    end

    // Result bank: a write and a stream read of the same word on one edge return the old word.
    always_ff @(posedge clk) begin
        if (res_we) begin
            res_bank[res_addr] <= res_data;
        end
    end

endmodule

// File: tb/tb_modexp_word_port.sv
module tb_modexp_word_port;

    localparam logic [63:0] NP = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [63:0] m_word, e_word, n_word, r_word, t_word;
    logic [63:0] nprime0_in;
    logic        loaded;
    logic        load_err;
    logic [63:0] nprime0;
    logic [2:0]  rd_sel;
    logic [5:0]  rd_addr;
    logic [63:0] rd_data;
    logic        res_we;
    logic [5:0]  res_addr;
    logic [63:0] res_data;
    logic        out_start;
    logic        res_valid;
    logic [63:0] res_out;
    logic        res_last;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [5:0]  addr;
        logic [63:0] off;
    } rd_vec_t;

    rd_vec_t vecs [9];

    modexp_word_port dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .m_word     (m_word),
        .e_word     (e_word),
        .n_word     (n_word),
        .r_word     (r_word),
        .t_word     (t_word),
        .nprime0_in (nprime0_in),
        .loaded     (loaded),
        .load_err   (load_err),
        .nprime0    (nprime0),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .res_we     (res_we),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .out_start  (out_start),
        .res_valid  (res_valid),
        .res_out    (res_out),
        .res_last   (res_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive a load of nbeats beats; word k of bank s is base + 100*s + k.
    task automatic do_load(input logic [63:0] base, input bit gapped, input int nbeats);
        load_start = 1'b1;
        nprime0_in = NP;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == 63) chk("loaded_before_last_beat", {63'd0, loaded}, 64'd0);
            in_valid = 1'b1;
            m_word = base + 64'(k);
            e_word = base + 64'(k) + 64'd100;
            n_word = base + 64'(k) + 64'd200;
            r_word = base + 64'(k) + 64'd300;
            t_word = base + 64'(k) + 64'd400;
            tick();
            in_valid = 1'b0;
            if (gapped && k < nbeats - 1) begin
                m_word = 64'hDEAD; e_word = 64'hDEAD; n_word = 64'hDEAD;
                r_word = 64'hDEAD; t_word = 64'hDEAD;
                if (k == 3) out_start = 1'b1;
                tick();
                out_start = 1'b0;
                if (k == 3) chk("out_start_in_load_ignored", {63'd0, res_valid}, 64'd0);
            end
        end
    endtask

    task automatic check_reads(input logic [63:0] base, input string tag);
        for (int i = 0; i < 9; i++) begin
            rd_sel  = vecs[i].sel;
            rd_addr = vecs[i].addr;
            tick();
            chk($sformatf("%s_rd%0d", tag, i), rd_data,
                (vecs[i].sel <= 3'd4) ? base + vecs[i].off : 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{3'd2, 6'd5,  64'd205};
        vecs[1] = '{3'd0, 6'd0,  64'd0};
        vecs[2] = '{3'd0, 6'd63, 64'd63};
        vecs[3] = '{3'd1, 6'd10, 64'd110};
        vecs[4] = '{3'd3, 6'd1,  64'd301};
        vecs[5] = '{3'd4, 6'd63, 64'd463};
        vecs[6] = '{3'd7, 6'd5,  64'd0};
        vecs[7] = '{3'd5, 6'd3,  64'd0};
        vecs[8] = '{3'd2, 6'd10, 64'd210};

        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; out_start = 1'b0;
        m_word = '0; e_word = '0; n_word = '0; r_word = '0; t_word = '0;
        nprime0_in = '0; rd_sel = '0; rd_addr = '0;
        res_we = 1'b0; res_addr = '0; res_data = '0;
        tick();
        tick();
        chk("rst_loaded",    {63'd0, loaded},    64'd0);
        chk("rst_load_err",  {63'd0, load_err},  64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_nprime0",   nprime0,            64'd0);
        chk("rst_rd_data",   rd_data,            64'd0);
        reset = 1'b0;
        tick();

        // Beat with no open load.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("idle_beat_load_err", {63'd0, load_err}, 64'd1);

        // Back-to-back load.
        do_load(64'd0, 1'b0, 64);
        chk("load_loaded",   {63'd0, loaded},   64'd1);
        chk("load_err_clr",  {63'd0, load_err}, 64'd0);
        chk("load_nprime0",  nprime0,           NP);
        chk("load_busy_low", {63'd0, busy},     64'd0);
        check_reads(64'd0, "b2b");

        // Beat in READY must not write and must flag.
        in_valid = 1'b1;
        m_word = 64'hBAD; e_word = 64'hBAD; n_word = 64'hBAD; r_word = 64'hBAD; t_word = 64'hBAD;
        tick();
        in_valid = 1'b0;
        chk("ready_beat_load_err", {63'd0, load_err}, 64'd1);
        check_reads(64'd0, "after_err");

        // Gapped load with out_start attempted during a gap.
        do_load(64'd1000, 1'b1, 64);
        chk("gap_loaded",   {63'd0, loaded},   64'd1);
        chk("gap_err_clr",  {63'd0, load_err}, 64'd0);
        check_reads(64'd1000, "gap");

        // Fill the result bank and stream it out.
        for (int a = 0; a < 64; a++) begin
            res_we = 1'b1; res_addr = 6'(a); res_data = 64'(a) ^ 64'hFFFF;
            tick();
        end
        res_we = 1'b0;
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        chk("stream_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("s1_valid%0d", i), {63'd0, res_valid}, 64'd1);
            chk($sformatf("s1_word%0d", i),  res_out, 64'(i) ^ 64'hFFFF);
            chk($sformatf("s1_last%0d", i),  {63'd0, res_last}, (i == 63) ? 64'd1 : 64'd0);
            tick();
        end
        chk("s1_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("s1_busy_drop",  {63'd0, busy},      64'd0);
        chk("s1_loaded",     {63'd0, loaded},    64'd1);

        // Second stream: read-before-write, write-then-read, and abort at word 20.
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            chk($sformatf("s2_word%0d", i), res_out,
                (i == 7) ? 64'hBEEF : (64'(i) ^ 64'hFFFF));
            if (i == 4) begin res_we = 1'b1; res_addr = 6'd5; res_data = 64'hDEAD; end
            if (i == 5) begin res_we = 1'b1; res_addr = 6'd7; res_data = 64'hBEEF; end
            if (i == 20) load_start = 1'b1;
            tick();
            res_we = 1'b0;
        end
        load_start = 1'b0;
        chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
        chk("abort_res_last",  {63'd0, res_last},  64'd0);
        chk("abort_loaded",    {63'd0, loaded},    64'd0);
        chk("abort_busy",      {63'd0, busy},      64'd1);
        do_load(64'd2000, 1'b0, 64);
        chk("reload_loaded", {63'd0, loaded}, 64'd1);
        check_reads(64'd2000, "reload");

        // Reset in the middle of a load.
        do_load(64'd3000, 1'b0, 30);
        reset = 1'b1;
        tick();
        chk("mid_rst_loaded",    {63'd0, loaded},    64'd0);
        chk("mid_rst_busy",      {63'd0, busy},      64'd0);
        chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("mid_rst_nprime0",   nprime0,            64'd0);
        chk("mid_rst_rd_data",   rd_data,            64'd0);
        chk("mid_rst_res_out",   res_out,            64'd0);
        reset = 1'b0;
        tick();
        do_load(64'd4000, 1'b0, 64);
        chk("post_rst_loaded", {63'd0, loaded}, 64'd1);
        chk("post_rst_np",     nprime0,         NP);
        check_reads(64'd4000, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
